// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, branch condition codes, flag bit indices and sequencing states
package proc_pkg;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_RED = 4'h2, OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW = 4'h8, OP_SW = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
    localparam logic [3:0] OP_B = 4'hC, OP_BR = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

    localparam logic [2:0] CC_NE = 3'd0, CC_EQ = 3'd1, CC_GT = 3'd2, CC_LT = 3'd3;
    localparam logic [2:0] CC_GE = 3'd4, CC_LE = 3'd5, CC_OV = 3'd6, CC_AL = 3'd7;

    localparam int FLG_Z = 0;
    localparam int FLG_V = 1;
    localparam int FLG_N = 2;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    function automatic logic sets_all_flags(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB;
    endfunction

    function automatic logic sets_z_flag(input logic [3:0] op);
        return op == OP_XOR || op == OP_SLL || op == OP_SRA || op == OP_ROR;
    endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: evaluates a 3-bit branch condition against the Z/V/N flags
module branch_cond
    import proc_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] ccc,
    output logic       taken
);
    logic z, v, n;

    assign z = flags[FLG_Z];
    assign v = flags[FLG_V];
    assign n = flags[FLG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE: taken = !z;
            CC_EQ: taken = z;
            CC_GT: taken = !z && !n;
            CC_LT: taken = n;
            CC_GE: taken = z || !n;
            CC_LE: taken = n || z;
            CC_OV: taken = v;
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: flag register, ID branch resolution, load-use/flag hazard stalls,
// HLT drain sequencing and a saturating stall counter.
module hazard_ctrl
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [2:0]       id_ccc,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [3:0]       ex_rd,
    input  logic [2:0]       ex_flag,
    output logic [2:0]       flags,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             br_taken,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t     state, next_state;
    logic [1:0] drain_cnt, next_cnt;
    logic       running, id_br, ex_sets, lu, fh, stall, cond, hlt_go;

    assign running = state == RUN;
    assign id_br   = id_valid && (id_opcode == OP_B || id_opcode == OP_BR);
    assign ex_sets = ex_valid && (sets_all_flags(ex_opcode) || sets_z_flag(ex_opcode));

    assign lu = ex_valid && ex_opcode == OP_LW && ex_rd != 4'd0 && id_valid &&
                ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    assign fh = id_br && id_ccc != CC_AL && ex_sets;

    assign stall    = running && (lu || fh);
    assign br_taken = running && id_br && !stall && cond;
    assign hlt_go   = running && id_valid && id_opcode == OP_HLT && !stall;
    assign halted   = state == HALTED;

    // Resolution uses the registered flags, never the EX flags in flight.
    branch_cond u_cond (
        .flags (flags),
        .ccc   (id_ccc),
        .taken (cond)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (ex_valid) begin
            if (sets_all_flags(ex_opcode))
                flags <= ex_flag;
            else if (sets_z_flag(ex_opcode))
                flags[FLG_Z] <= ex_flag[FLG_Z];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state  = state;
        next_cnt    = drain_cnt;
        pc_stall    = stall;
        ifid_stall  = stall;
        idex_bubble = stall;
        ifid_flush  = br_taken;
        case (state)
            RUN: begin
                if (hlt_go) begin
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                    next_cnt   = 2'd3;
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                next_cnt   = drain_cnt - 2'd1;
                next_state = drain_cnt == 2'd1 ? HALTED : DRAIN;
            end
            HALTED: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
